// File: rtl/fun_inv_pkg.sv
// Shared definitions for the fun_inv inverse unit: FSM encoding and fixed sizing.
package fun_inv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_WORK   = 3'd1,
    SUB       = 3'd2,
    CBRT_ON   = 3'd3,
    CBRT_WORK = 3'd4
  } state_t;

  localparam int unsigned SQ_CYCLES  = 8;
  localparam int unsigned CBRT_ITERS = 6;
  localparam int unsigned RADICAND_W = 16;

endpackage

// File: rtl/fun_inv_cbrt.sv
// Iterative 16-bit integer cube root: one 3-bit digit per cycle, busy for six cycles.
module cbrt_u16
  import fun_inv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] x_bi,
  output logic        busy_o,
  output logic [7:0]  y_bo
);

  logic                  busy_q;
  logic [2:0]            iter_q;
  logic [RADICAND_W-1:0] x_q;
  logic [7:0]            r_q;

  logic [4:0]            shamt;
  logic [17:0]           r2;
  logic [17:0]           t_base;
  logic [17:0]           t;
  logic                  take;

  // Shift amount walks 15, 12, ..., 0 as iter goes 0..5.
  always_comb begin
    shamt  = 5'd15 - 5'({iter_q, 1'b0}) - 5'(iter_q);
    r2     = {9'd0, r_q, 1'b0};
    t_base = 18'd3 * r2 * (r2 + 18'd1) + 18'd1;
    t      = t_base << shamt;
    take   = ({2'b00, x_q} >= t);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      x_q    <= '0;
      r_q    <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q <= 1'b1;
        iter_q <= '0;
        x_q    <= x_bi;
        r_q    <= '0;
      end
    end else begin
      if (take) begin
        x_q <= x_q - t[15:0];
        r_q <= r2[7:0] + 8'd1;
      end else begin
        r_q <= r2[7:0];
      end
      iter_q <= iter_q + 3'd1;
      if (iter_q == 3'(CBRT_ITERS - 1))
        busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = r_q;

endmodule

// File: rtl/fun_inv.sv
// Inverse of y = sqrt(a + b^3): computes b = floor(cbrt(y*y - a)) with a start/busy handshake.
module fun_inv
  import fun_inv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] a_bi,
  input  logic [7:0] y_bi,
  output logic       busy_o,
  output logic [7:0] b_bo,
  output logic       err_o
);

  state_t state_q, state_d;

  logic [7:0]            a_q;
  logic [7:0]            y_q;
  logic [15:0]           acc_q;
  logic [2:0]            cnt_q;
  logic [RADICAND_W-1:0] rad_q;
  logic [7:0]            b_q;
  logic                  err_q;
  logic [16:0]           diff;

  logic                  cb_start;
  logic                  cb_busy;
  logic [7:0]            cb_y;

  assign diff = {1'b0, acc_q} - {9'd0, a_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cb_start = 1'b0;
    case (state_q)
      IDLE:      if (start_i) state_d = SQ_WORK;
      SQ_WORK:   if (cnt_q == 3'(SQ_CYCLES - 1)) state_d = SUB;
      SUB:       state_d = diff[16] ? IDLE : CBRT_ON;
      CBRT_ON: begin
        cb_start = 1'b1;
        state_d  = CBRT_WORK;
      end
      CBRT_WORK: if (!cb_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Squarer: one bit of y per cycle, LSB first, adding the shifted multiplicand.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      rad_q <= '0;
      b_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q   <= a_bi;
            y_q   <= y_bi;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        SQ_WORK: begin
          if (y_q[cnt_q])
            acc_q <= acc_q + ({8'd0, y_q} << cnt_q);
          cnt_q <= cnt_q + 3'd1;
        end
        SUB: begin
          if (diff[16]) begin
            err_q <= 1'b1;
            b_q   <= '0;
          end else begin
            rad_q <= diff[15:0];
          end
        end
        CBRT_WORK: begin
          if (!cb_busy) begin
            b_q   <= cb_y;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  cbrt_u16 u_cbrt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (cb_start),
    .x_bi    (rad_q),
    .busy_o  (cb_busy),
    .y_bo    (cb_y)
  );

  assign busy_o = (state_q != IDLE);
  assign b_bo   = b_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_fun_inv.sv
// Directed self-checking bench for fun_inv.
module tb_fun_inv;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic [7:0] a_bi;
  logic [7:0] y_bi;
  logic       busy_o;
  logic [7:0] b_bo;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  int n;

  fun_inv dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .y_bi    (y_bi),
    .busy_o  (busy_o),
    .b_bo    (b_bo),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts busy samples from the current sample point until busy drops (bounded).
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy_o && cnt < 100) begin
      cnt++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run_op(input logic [7:0] y, input logic [7:0] a, output int lat);
    @(negedge clk_i);
    y_bi = y; a_bi = a; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle(lat);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; a_bi = '0; y_bi = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_b",    32'(b_bo),   32'd0);
    check("rst_err",  32'(err_o),  32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op(8'd3, 8'd1, n);
    check("y3a1_lat", 32'(n),     32'd17);
    check("y3a1_b",   32'(b_bo),  32'd2);
    check("y3a1_err", 32'(err_o), 32'd0);

    run_op(8'd255, 8'd0, n);
    check("y255_lat", 32'(n),     32'd17);
    check("y255_b",   32'(b_bo),  32'd40);
    check("y255_err", 32'(err_o), 32'd0);

    run_op(8'd5, 8'd0, n);
    check("y5a0_b", 32'(b_bo), 32'd2);
    run_op(8'd6, 8'd9, n);
    check("y6a9_b", 32'(b_bo), 32'd3);

    run_op(8'd2, 8'd5, n);
    check("neg_lat", 32'(n),     32'd9);
    check("neg_err", 32'(err_o), 32'd1);
    check("neg_b",   32'(b_bo),  32'd0);

    run_op(8'd0, 8'd0, n);
    check("zero_lat", 32'(n),     32'd17);
    check("zero_b",   32'(b_bo),  32'd0);
    check("zero_err", 32'(err_o), 32'd0);

    // Start during busy with different operands must be ignored.
    @(negedge clk_i);
    y_bi = 8'd3; a_bi = 8'd1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    y_bi = 8'd255; a_bi = 8'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle(n);
    check("ign_lat", 32'(n),    32'd13);
    check("ign_b",   32'(b_bo), 32'd2);

    // Start held across completion; operands changed after latch.
    @(negedge clk_i);
    y_bi = 8'd5; a_bi = 8'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    check("hold_b_kept", 32'(b_bo), 32'd2);
    y_bi = 8'd6; a_bi = 8'd9;
    wait_idle(n);
    check("hold1_lat", 32'(n),    32'd17);
    check("hold1_b",   32'(b_bo), 32'd2);
    @(posedge clk_i); #1;
    check("hold_restart", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    wait_idle(n);
    check("hold2_lat", 32'(n),    32'd17);
    check("hold2_b",   32'(b_bo), 32'd3);

    // Reset in cycle 12 of an operation.
    @(negedge clk_i);
    y_bi = 8'd255; a_bi = 8'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_b",    32'(b_bo),   32'd0);
    check("mid_rst_err",  32'(err_o),  32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op(8'd3, 8'd1, n);
    check("post_rst_lat", 32'(n),    32'd17);
    check("post_rst_b",   32'(b_bo), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
